// File: rtl/crypto_stream_buffer.sv
// crypto_stream_buffer: host-side word FIFO in, block packer towards a cipher
// core, block unpacker into a host-side word FIFO out. A bypass path moves words
// straight from the input FIFO to the output FIFO when no block is in flight.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no block in flight; bypass moves words here when enabled
// GATHER     | popping input words into the block register
// ISSUE      | block offered to core, held until i_blk_ready
// WAIT_RES   | waiting for the core result (o_res_ready=1)
// UNPACK     | writing result words into the output FIFO, MSB word first
module crypto_stream_buffer #(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 256,
    parameter int WORDS_PER_BLK = 4,
    parameter int AFULL_MARGIN  = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_rst_control,
    input  logic                                  i_bypass,
    input  logic                                  i_write_in,
    input  logic [DATA_W-1:0]                     i_data_in,
    output logic                                  o_afull_in,
    output logic [$clog2(DEPTH):0]                o_usedw_in,
    output logic                                  o_blk_valid,
    output logic [DATA_W*WORDS_PER_BLK-1:0]       o_blk_data,
    input  logic                                  i_blk_ready,
    input  logic                                  i_res_valid,
    input  logic [DATA_W*WORDS_PER_BLK-1:0]       i_res_data,
    output logic                                  o_res_ready,
    input  logic                                  i_read_out,
    output logic                                  o_empty_out,
    output logic [DATA_W-1:0]                     o_q_out,
    output logic [$clog2(DEPTH):0]                o_usedw_out,
    output logic [15:0]                           o_blk_count
);

    localparam int BLK_W = DATA_W * WORDS_PER_BLK;
    localparam int AW    = $clog2(DEPTH);
    localparam int UW    = AW + 1;
    localparam int CW    = $clog2(WORDS_PER_BLK + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GATHER   = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_UNPACK   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_in  [DEPTH];
    logic [DATA_W-1:0] mem_out [DEPTH];

    logic [AW-1:0]     wr_ptr_in_q,  wr_ptr_in_d;
    logic [AW-1:0]     rd_ptr_in_q,  rd_ptr_in_d;
    logic [AW-1:0]     wr_ptr_out_q, wr_ptr_out_d;
    logic [AW-1:0]     rd_ptr_out_q, rd_ptr_out_d;
    logic [UW-1:0]     used_in_q,    used_in_d;
    logic [UW-1:0]     used_out_q,   used_out_d;
    logic [BLK_W-1:0]  blk_q,        blk_d;
    logic [BLK_W-1:0]  res_q,        res_d;
    logic [CW-1:0]     words_left_q, words_left_d;
    logic [CW-1:0]     unpack_left_q, unpack_left_d;
    logic [15:0]       blk_count_q,  blk_count_d;

    logic              empty_in, full_in, empty_out, full_out;
    logic              space_ok;
    logic              push_in, pop_in, push_out, rd_out;
    logic              gather_pop, unpack_push, bypass_move;
    logic              blk_valid, res_ready;
    logic [DATA_W-1:0] head_in, din_out;

    assign empty_in  = (used_in_q == '0);
    assign full_in   = (used_in_q == UW'(DEPTH));
    assign empty_out = (used_out_q == '0);
    assign full_out  = (used_out_q == UW'(DEPTH));
    assign space_ok  = ((UW'(DEPTH) - used_out_q) >= UW'(WORDS_PER_BLK));
    assign head_in   = mem_in[rd_ptr_in_q];

    // A write in the same cycle as a soft clear is dropped.
    assign push_in = i_write_in && !full_in && !i_rst_control;
    assign rd_out  = i_read_out && !empty_out;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; soft clear always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!i_bypass && !empty_in) state_d = ST_GATHER;
            end
            ST_GATHER: begin
                // Leave in the same cycle as the last pop so valid follows 1 cycle later.
                if ((words_left_d == '0) && space_ok) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i_blk_ready) state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (i_res_valid) state_d = ST_UNPACK;
            end
            ST_UNPACK: begin
                if (unpack_push && (unpack_left_q == CW'(1))) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_rst_control) state_d = ST_IDLE;
    end

    // FSM outputs and per-state datapath strobes.
    always_comb begin
        blk_valid   = 1'b0;
        res_ready   = 1'b0;
        gather_pop  = 1'b0;
        unpack_push = 1'b0;
        bypass_move = 1'b0;
        case (state_q)
            ST_IDLE:     bypass_move = i_bypass && !empty_in && !full_out;
            ST_GATHER:   gather_pop  = !empty_in && (words_left_q != '0);
            ST_ISSUE:    blk_valid   = 1'b1;
            ST_WAIT_RES: res_ready   = 1'b1;
            ST_UNPACK:   unpack_push = !full_out;
            default: ;
        endcase
    end

    // FIFO pointers, occupancy, block packing/unpacking and block counter.
    always_comb begin
        wr_ptr_in_d   = wr_ptr_in_q;
        rd_ptr_in_d   = rd_ptr_in_q;
        wr_ptr_out_d  = wr_ptr_out_q;
        rd_ptr_out_d  = rd_ptr_out_q;
        used_in_d     = used_in_q;
        used_out_d    = used_out_q;
        blk_d         = blk_q;
        res_d         = res_q;
        words_left_d  = words_left_q;
        unpack_left_d = unpack_left_q;
        blk_count_d   = blk_count_q;

        pop_in   = gather_pop || bypass_move;
        push_out = unpack_push || bypass_move;
        din_out  = bypass_move ? head_in : res_q[BLK_W-1 -: DATA_W];

        if (push_in) wr_ptr_in_d  = wr_ptr_in_q + AW'(1);
        if (pop_in)  rd_ptr_in_d  = rd_ptr_in_q + AW'(1);
        if (push_out) wr_ptr_out_d = wr_ptr_out_q + AW'(1);
        if (rd_out)  rd_ptr_out_d = rd_ptr_out_q + AW'(1);

        case ({push_in, pop_in})
            2'b10:   used_in_d = used_in_q + UW'(1);
            2'b01:   used_in_d = used_in_q - UW'(1);
            default: used_in_d = used_in_q;
        endcase
        case ({push_out, rd_out})
            2'b10:   used_out_d = used_out_q + UW'(1);
            2'b01:   used_out_d = used_out_q - UW'(1);
            default: used_out_d = used_out_q;
        endcase

        if (state_q == ST_IDLE) words_left_d = CW'(WORDS_PER_BLK);

        // Shifting in at the LSB leaves the first word in the MSBs once full.
        if (gather_pop) begin
            blk_d        = (blk_q << DATA_W) | BLK_W'(head_in);
            words_left_d = words_left_q - CW'(1);
        end

        if (res_ready && i_res_valid) begin
            res_d         = i_res_data;
            unpack_left_d = CW'(WORDS_PER_BLK);
        end

        if (unpack_push) begin
            res_d         = res_q << DATA_W;
            unpack_left_d = unpack_left_q - CW'(1);
            if (unpack_left_q == CW'(1)) blk_count_d = blk_count_q + 16'd1;
        end

        // Soft clear: everything back to reset values except the block counter.
        if (i_rst_control) begin
            wr_ptr_in_d   = '0;
            rd_ptr_in_d   = '0;
            wr_ptr_out_d  = '0;
            rd_ptr_out_d  = '0;
            used_in_d     = '0;
            used_out_d    = '0;
            blk_d         = '0;
            res_d         = '0;
            words_left_d  = CW'(WORDS_PER_BLK);
            unpack_left_d = '0;
            blk_count_d   = blk_count_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_in_q   <= '0;
            rd_ptr_in_q   <= '0;
            wr_ptr_out_q  <= '0;
            rd_ptr_out_q  <= '0;
            used_in_q     <= '0;
            used_out_q    <= '0;
            blk_q         <= '0;
            res_q         <= '0;
            words_left_q  <= CW'(WORDS_PER_BLK);
            unpack_left_q <= '0;
            blk_count_q   <= '0;
        end else begin
            wr_ptr_in_q   <= wr_ptr_in_d;
            rd_ptr_in_q   <= rd_ptr_in_d;
            wr_ptr_out_q  <= wr_ptr_out_d;
            rd_ptr_out_q  <= rd_ptr_out_d;
            used_in_q     <= used_in_d;
            used_out_q    <= used_out_d;
            blk_q         <= blk_d;
            res_q         <= res_d;
            words_left_q  <= words_left_d;
            unpack_left_q <= unpack_left_d;
            blk_count_q   <= blk_count_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (push_in)  mem_in[wr_ptr_in_q]   <= i_data_in;
        if (push_out) mem_out[wr_ptr_out_q] <= din_out;
    end

    assign o_usedw_in  = used_in_q;
    assign o_afull_in  = (used_in_q >= UW'(DEPTH - AFULL_MARGIN));
    assign o_blk_valid = blk_valid;
    assign o_blk_data  = blk_q;
    assign o_res_ready = res_ready;
    assign o_empty_out = empty_out;
    assign o_q_out     = empty_out ? '0 : mem_out[rd_ptr_out_q];
    assign o_usedw_out = used_out_q;
    assign o_blk_count = blk_count_q;

endmodule

// File: tb/tb_crypto_stream_buffer.sv
// Directed bench for crypto_stream_buffer with default parameters.
module tb_crypto_stream_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int WPB    = 4;
    localparam int BLK_W  = DATA_W * WPB;
    localparam int UW     = $clog2(DEPTH) + 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_rst_control = 1'b0;
    logic              i_bypass = 1'b0;
    logic              i_write_in = 1'b0;
    logic [DATA_W-1:0] i_data_in = '0;
    logic              o_afull_in;
    logic [UW-1:0]     o_usedw_in;
    logic              o_blk_valid;
    logic [BLK_W-1:0]  o_blk_data;
    logic              i_blk_ready = 1'b0;
    logic              i_res_valid = 1'b0;
    logic [BLK_W-1:0]  i_res_data = '0;
    logic              o_res_ready;
    logic              i_read_out = 1'b0;
    logic              o_empty_out;
    logic [DATA_W-1:0] o_q_out;
    logic [UW-1:0]     o_usedw_out;
    logic [15:0]       o_blk_count;

    int n_cmp = 0;
    int n_bad = 0;

    crypto_stream_buffer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rst_control(i_rst_control),
        .i_bypass(i_bypass), .i_write_in(i_write_in), .i_data_in(i_data_in),
        .o_afull_in(o_afull_in), .o_usedw_in(o_usedw_in),
        .o_blk_valid(o_blk_valid), .o_blk_data(o_blk_data), .i_blk_ready(i_blk_ready),
        .i_res_valid(i_res_valid), .i_res_data(i_res_data), .o_res_ready(o_res_ready),
        .i_read_out(i_read_out), .o_empty_out(o_empty_out), .o_q_out(o_q_out),
        .o_usedw_out(o_usedw_out), .o_blk_count(o_blk_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (o_usedw_in !== 0)     begin n_bad++; $display("FAIL rst_usedw_in got %0d want 0", o_usedw_in); end
        n_cmp++; if (o_usedw_out !== 0)    begin n_bad++; $display("FAIL rst_usedw_out got %0d want 0", o_usedw_out); end
        n_cmp++; if (o_empty_out !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b want 1", o_empty_out); end
        n_cmp++; if (o_afull_in !== 1'b0)  begin n_bad++; $display("FAIL rst_afull got %b want 0", o_afull_in); end
        n_cmp++; if (o_blk_valid !== 1'b0) begin n_bad++; $display("FAIL rst_blk_valid got %b want 0", o_blk_valid); end
        n_cmp++; if (o_res_ready !== 1'b0) begin n_bad++; $display("FAIL rst_res_ready got %b want 0", o_res_ready); end
        n_cmp++; if (o_blk_count !== 0)    begin n_bad++; $display("FAIL rst_blk_count got %0d want 0", o_blk_count); end
        n_cmp++; if (o_blk_data !== '0)    begin n_bad++; $display("FAIL rst_blk_data got %h want 0", o_blk_data); end
        n_cmp++; if (o_q_out !== '0)       begin n_bad++; $display("FAIL rst_q_out got %h want 0", o_q_out); end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_block();
        logic [DATA_W-1:0] exp_w [4];
        logic [BLK_W-1:0]  exp_blk;
        int n;
        exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222;
        exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
        exp_blk = 128'h11111111_22222222_33333333_44444444;
        i_blk_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_write_in = 1'b1; i_data_in = exp_w[i];
            tick();
        end
        i_write_in = 1'b0;
        n_cmp++; if (o_usedw_in !== 2) begin n_bad++; $display("FAIL basic_usedw_in got %0d want 2", o_usedw_in); end
        n = 0;
        while (o_blk_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL basic_issue_latency got %0d want 2", n); end
        n_cmp++; if (o_blk_data !== exp_blk) begin n_bad++; $display("FAIL basic_blk_data got %h want %h", o_blk_data, exp_blk); end
        tick();
        i_blk_ready = 1'b0;
        n_cmp++; if (o_res_ready !== 1'b1) begin n_bad++; $display("FAIL basic_res_ready got %b want 1", o_res_ready); end
        n_cmp++; if (o_blk_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop got %b want 0", o_blk_valid); end
        i_res_valid = 1'b1; i_res_data = exp_blk;
        tick();
        i_res_valid = 1'b0;
        n_cmp++; if (o_empty_out !== 1'b1) begin n_bad++; $display("FAIL basic_out_early got %b want 1", o_empty_out); end
        tick();
        n_cmp++; if (o_empty_out !== 1'b0) begin n_bad++; $display("FAIL basic_out_latency got %b want 0", o_empty_out); end
        n_cmp++; if (o_q_out !== exp_w[0]) begin n_bad++; $display("FAIL basic_first_word got %h want %h", o_q_out, exp_w[0]); end
        tick(); tick(); tick();
        n_cmp++; if (o_usedw_out !== 4) begin n_bad++; $display("FAIL basic_usedw_out got %0d want 4", o_usedw_out); end
        n_cmp++; if (o_blk_count !== 1) begin n_bad++; $display("FAIL basic_blk_count got %0d want 1", o_blk_count); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_q_out !== exp_w[i]) begin n_bad++; $display("FAIL basic_read%0d got %h want %h", i, o_q_out, exp_w[i]); end
            i_read_out = 1'b1;
            tick();
        end
        i_read_out = 1'b0;
        n_cmp++; if (o_empty_out !== 1'b1) begin n_bad++; $display("FAIL basic_drained got %b want 1", o_empty_out); end
    endtask

    task automatic test_space_stall();
        logic [DATA_W-1:0] blk_w [4];
        int n;
        bit seen_valid;
        blk_w[0] = 32'hA1A1A1A1; blk_w[1] = 32'hB2B2B2B2;
        blk_w[2] = 32'hC3C3C3C3; blk_w[3] = 32'hD4D4D4D4;
        i_blk_ready = 1'b0;
        i_bypass = 1'b1;
        for (int i = 0; i < DEPTH - 3; i++) begin
            i_write_in = 1'b1; i_data_in = 32'hA0000000 + i;
            tick();
        end
        i_write_in = 1'b0;
        n = 0;
        while (o_usedw_out !== UW'(DEPTH - 3) && n < 20) begin tick(); n++; end
        n_cmp++; if (o_usedw_out !== UW'(DEPTH - 3)) begin n_bad++; $display("FAIL stall_prefill got %0d want %0d", o_usedw_out, DEPTH - 3); end
        i_bypass = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_write_in = 1'b1; i_data_in = blk_w[i];
            tick();
        end
        i_write_in = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_blk_valid === 1'b1) seen_valid = 1'b1;
            tick();
        end
        n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_issue got %b want 0", seen_valid); end
        n_cmp++; if (o_usedw_in !== 0) begin n_bad++; $display("FAIL stall_gathered got %0d want 0", o_usedw_in); end
        n_cmp++; if (o_q_out !== 32'hA0000000) begin n_bad++; $display("FAIL stall_head got %h want a0000000", o_q_out); end
        i_read_out = 1'b1;
        tick();
        i_read_out = 1'b0;
        n_cmp++; if (o_blk_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid_early got %b want 0", o_blk_valid); end
        tick();
        n_cmp++; if (o_blk_valid !== 1'b1) begin n_bad++; $display("FAIL stall_issue got %b want 1", o_blk_valid); end
    endtask

    task automatic test_ready_hold();
        logic [BLK_W-1:0] exp_blk;
        int n_err;
        exp_blk = 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4;
        n_err = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_blk_valid !== 1'b1 || o_blk_data !== exp_blk) n_err++;
            tick();
        end
        n_cmp++; if (n_err !== 0) begin n_bad++; $display("FAIL hold_stable bad_cycles %0d want 0 (data %h)", n_err, o_blk_data); end
        n_cmp++; if (o_blk_data !== exp_blk) begin n_bad++; $display("FAIL hold_data got %h want %h", o_blk_data, exp_blk); end
        i_blk_ready = 1'b1;
        tick();
        i_blk_ready = 1'b0;
        n_cmp++; if (o_res_ready !== 1'b1) begin n_bad++; $display("FAIL hold_accept got %b want 1", o_res_ready); end
        n_cmp++; if (o_blk_valid !== 1'b0) begin n_bad++; $display("FAIL hold_valid_off got %b want 0", o_blk_valid); end
    endtask

    task automatic test_soft_clear_wait_res();
        i_rst_control = 1'b1;
        i_write_in = 1'b1; i_data_in = 32'hDEADBEEF;
        tick();
        i_rst_control = 1'b0;
        i_write_in = 1'b0;
        n_cmp++; if (o_res_ready !== 1'b0) begin n_bad++; $display("FAIL clr_res_ready got %b want 0", o_res_ready); end
        n_cmp++; if (o_usedw_in !== 0)     begin n_bad++; $display("FAIL clr_write_dropped got %0d want 0", o_usedw_in); end
        n_cmp++; if (o_usedw_out !== 0)    begin n_bad++; $display("FAIL clr_usedw_out got %0d want 0", o_usedw_out); end
        n_cmp++; if (o_blk_data !== '0)    begin n_bad++; $display("FAIL clr_blk_data got %h want 0", o_blk_data); end
        i_res_valid = 1'b1; i_res_data = 128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003;
        tick(); tick(); tick();
        i_res_valid = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (o_empty_out !== 1'b1) begin n_bad++; $display("FAIL clr_res_ignored got %b want 1", o_empty_out); end
        n_cmp++; if (o_usedw_out !== 0)    begin n_bad++; $display("FAIL clr_out_still_empty got %0d want 0", o_usedw_out); end
        n_cmp++; if (o_blk_count !== 1)    begin n_bad++; $display("FAIL clr_blk_count got %0d want 1", o_blk_count); end
        n_cmp++; if (o_q_out !== '0)       begin n_bad++; $display("FAIL clr_q_out got %h want 0", o_q_out); end
    endtask

    task automatic test_bypass_fill();
        i_bypass = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            i_write_in = 1'b1; i_data_in = 32'hB0000000 + i;
            tick();
        end
        i_write_in = 1'b0;
        tick();
        n_cmp++; if (o_usedw_out !== UW'(DEPTH)) begin n_bad++; $display("FAIL byp_out_full got %0d want %0d", o_usedw_out, DEPTH); end
        n_cmp++; if (o_usedw_in !== 1)  begin n_bad++; $display("FAIL byp_in_left got %0d want 1", o_usedw_in); end
        n_cmp++; if (o_blk_count !== 1) begin n_bad++; $display("FAIL byp_blk_count got %0d want 1", o_blk_count); end
        n_cmp++; if (o_q_out !== 32'hB0000000) begin n_bad++; $display("FAIL byp_head got %h want b0000000", o_q_out); end
        for (int i = 0; i < DEPTH - 8 - 2; i++) begin
            i_write_in = 1'b1; i_data_in = 32'hC0000000 + i;
            tick();
        end
        i_write_in = 1'b0;
        n_cmp++; if (o_usedw_in !== UW'(DEPTH - 9)) begin n_bad++; $display("FAIL afull_below_used got %0d want %0d", o_usedw_in, DEPTH - 9); end
        n_cmp++; if (o_afull_in !== 1'b0) begin n_bad++; $display("FAIL afull_below got %b want 0", o_afull_in); end
        i_write_in = 1'b1;
        tick();
        i_write_in = 1'b0;
        n_cmp++; if (o_afull_in !== 1'b1) begin n_bad++; $display("FAIL afull_at got %b want 1", o_afull_in); end
        for (int i = 0; i < 9; i++) begin
            i_write_in = 1'b1;
            tick();
        end
        i_write_in = 1'b0;
        n_cmp++; if (o_usedw_in !== UW'(DEPTH)) begin n_bad++; $display("FAIL in_full_ignored got %0d want %0d", o_usedw_in, DEPTH); end
        i_write_in = 1'b1; i_read_out = 1'b1;
        tick();
        i_read_out = 1'b0;
        n_cmp++; if (o_usedw_out !== UW'(DEPTH - 1)) begin n_bad++; $display("FAIL out_full_rd got %0d want %0d", o_usedw_out, DEPTH - 1); end
        n_cmp++; if (o_usedw_in !== UW'(DEPTH)) begin n_bad++; $display("FAIL in_full_wr got %0d want %0d", o_usedw_in, DEPTH); end
        n_cmp++; if (o_q_out !== 32'hB0000001) begin n_bad++; $display("FAIL out_advance got %h want b0000001", o_q_out); end
        tick();
        i_write_in = 1'b0;
        n_cmp++; if (o_usedw_in !== UW'(DEPTH - 1)) begin n_bad++; $display("FAIL in_full_wr_rd got %0d want %0d", o_usedw_in, DEPTH - 1); end
        n_cmp++; if (o_usedw_out !== UW'(DEPTH)) begin n_bad++; $display("FAIL out_refill got %0d want %0d", o_usedw_out, DEPTH); end
        i_bypass = 1'b0;
        i_rst_control = 1'b1;
        tick();
        i_rst_control = 1'b0;
        n_cmp++; if (o_usedw_in !== 0 || o_usedw_out !== 0 || o_afull_in !== 1'b0) begin
            n_bad++; $display("FAIL byp_clear got in %0d out %0d afull %b want 0 0 0", o_usedw_in, o_usedw_out, o_afull_in);
        end
    endtask

    task automatic test_async_reset_unpack();
        int n;
        i_blk_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_write_in = 1'b1; i_data_in = 32'h01010101 * (i + 1);
            tick();
        end
        i_write_in = 1'b0;
        n = 0;
        while (o_blk_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_cmp++; if (o_blk_valid !== 1'b1) begin n_bad++; $display("FAIL ar_issue_timeout got %b want 1", o_blk_valid); end
        tick();
        i_blk_ready = 1'b0;
        i_res_valid = 1'b1; i_res_data = 128'h5555AAAA_66667777_88889999_AAAABBBB;
        tick();
        i_res_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (o_usedw_out !== 2) begin n_bad++; $display("FAIL ar_mid_unpack got %0d want 2", o_usedw_out); end
        n_cmp++; if (o_q_out !== 32'h5555AAAA) begin n_bad++; $display("FAIL ar_unpack_word got %h want 5555aaaa", o_q_out); end
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_usedw_out !== 0)    begin n_bad++; $display("FAIL ar_usedw_out got %0d want 0", o_usedw_out); end
        n_cmp++; if (o_empty_out !== 1'b1) begin n_bad++; $display("FAIL ar_empty got %b want 1", o_empty_out); end
        n_cmp++; if (o_q_out !== '0)       begin n_bad++; $display("FAIL ar_q_out got %h want 0", o_q_out); end
        n_cmp++; if (o_blk_count !== 0)    begin n_bad++; $display("FAIL ar_blk_count got %0d want 0", o_blk_count); end
        n_cmp++; if (o_blk_data !== '0)    begin n_bad++; $display("FAIL ar_blk_data got %h want 0", o_blk_data); end
        n_cmp++; if (o_blk_valid !== 1'b0 || o_res_ready !== 1'b0) begin
            n_bad++; $display("FAIL ar_handshake got valid %b ready %b want 0 0", o_blk_valid, o_res_ready);
        end
        n_cmp++; if (o_usedw_in !== 0 || o_afull_in !== 1'b0) begin
            n_bad++; $display("FAIL ar_input got used %0d afull %b want 0 0", o_usedw_in, o_afull_in);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_block();
        test_space_stall();
        test_ready_hold();
        test_soft_clear_wait_res();
        test_bypass_fill();
        test_async_reset_unpack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
